// File: rtl/nbit_serial_comparator.sv
// Iterative WIDTH-bit magnitude comparator: compares CHUNK bits per cycle, MSB chunk first,
// and stops at the first unequal chunk. Supports unsigned and two's-complement operands.
module nbit_serial_comparator #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [2:0]       F
);

    localparam int unsigned N    = WIDTH / CHUNK;
    localparam int unsigned IDXW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(N - 1);

    typedef enum logic [1:0] {StIdle, StCmp, StDone} state_e;

    state_e           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             mode_q;
    logic [IDXW-1:0]  idx;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [CHUNK-1:0] ca;
    logic [CHUNK-1:0] cb;
    logic             chunk_ne;
    logic             chunk_gt;

    // Select the current chunk by shifting it up to the MSB end of the operand.
    always_comb begin
        a_sh = a_q << (idx * CHUNK);
        b_sh = b_q << (idx * CHUNK);
        ca   = a_sh[WIDTH-1 -: CHUNK];
        cb   = b_sh[WIDTH-1 -: CHUNK];
        // Flipping both sign bits maps two's complement onto an unsigned ordering.
        if (mode_q && (idx == '0)) begin
            ca[CHUNK-1] = ~ca[CHUNK-1];
            cb[CHUNK-1] = ~cb[CHUNK-1];
        end
        chunk_ne = (ca != cb);
        chunk_gt = (ca > cb);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= StIdle;
            a_q    <= '0;
            b_q    <= '0;
            mode_q <= 1'b0;
            idx    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            F      <= 3'b000;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle, StDone: begin
                    if (start) begin
                        a_q    <= A;
                        b_q    <= B;
                        mode_q <= signed_mode;
                        idx    <= '0;
                        busy   <= 1'b1;
                        state  <= StCmp;
                    end else begin
                        state <= StIdle;
                    end
                end
                StCmp: begin
                    if (chunk_ne || (idx == LAST)) begin
                        if (!chunk_ne) begin
                            F <= 3'b010;
                        end else if (chunk_gt) begin
                            F <= 3'b100;
                        end else begin
                            F <= 3'b001;
                        end
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= StDone;
                    end else begin
                        idx <= idx + IDXW'(1);
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule
